cons: RTL and testbench



---
 rtl/cons.sv | 86 ++++++++
 tb/tb_cons.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cons.sv
// cons: consumer stage buffering the producer's val/data stream in a show-ahead FIFO
// with a valid/ready output, a running byte sum and a saturating overflow-drop counter.
`default_nettype none

module cons #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int SW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          val,
  input  logic [DW-1:0] data,
  input  logic          out_rdy,
  output logic          out_val,
  output logic [DW-1:0] out_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [7:0]    drop_cnt,
  output logic [SW-1:0] sum
);

  localparam logic [AW:0] c_depth = DEPTH[AW:0];

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_drop_cnt;
  logic [SW-1:0] r_sum;

  logic w_pop;
  logic w_push;
  logic w_drop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == c_depth);
  assign out_val  = !empty;
  assign out_data = empty ? '0 : r_mem[r_rd_ptr];
  assign count    = r_count;
  assign drop_cnt = r_drop_cnt;
  assign sum      = r_sum;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_pop  = out_val & out_rdy;
  assign w_push = val & (!full | w_pop);
  assign w_drop = val & full & !w_pop;

  // Storage is intentionally left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_sum      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_sum    <= r_sum + SW'(data);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
      if (w_drop && (r_drop_cnt != 8'hff)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cons.sv
// tb_cons: randomized self-checking bench for cons against a queue-based reference model.
`default_nettype none

module tb_cons;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic       val;
  logic [7:0] data;
  logic       out_rdy;
  logic       out_val;
  logic [7:0] out_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic [7:0] drop_cnt;
  logic [15:0] sum;

  cons #(.DW(8), .DEPTH(DEPTH), .AW(3), .SW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .val      (val),
    .data     (data),
    .out_rdy  (out_rdy),
    .out_val  (out_val),
    .out_data (out_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .drop_cnt (drop_cnt),
    .sum      (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [$];
  int         msum  = 0;
  int         mdrop = 0;
  int         bsum  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    msum  = 0;
    mdrop = 0;
  endtask

  task automatic check_all(input string tag);
    int exp_head;
    exp_head = (mq.size() != 0) ? int'(mq[0]) : 0;
    chk({tag, "_count"},   int'(count),    mq.size());
    chk({tag, "_full"},    int'(full),     int'(mq.size() == DEPTH));
    chk({tag, "_empty"},   int'(empty),    int'(mq.size() == 0));
    chk({tag, "_outval"},  int'(out_val),  int'(mq.size() != 0));
    chk({tag, "_outdata"}, int'(out_data), exp_head);
    chk({tag, "_drop"},    int'(drop_cnt), mdrop);
    chk({tag, "_sum"},     int'(sum),      msum);
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then check.
  task automatic step(input string tag);
    bit         mfull, mpop, mpush;
    logic [7:0] tmp;
    if (rst) begin
      model_clear();
    end else begin
      mfull = (mq.size() == DEPTH);
      mpop  = (mq.size() != 0) && out_rdy;
      mpush = val && (!mfull || mpop);
      if (mpop) tmp = mq.pop_front();
      if (mpush) begin
        mq.push_back(data);
        msum = (msum + int'(data)) % 65536;
      end
      if (val && mfull && !mpop && mdrop < 255) mdrop++;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Reset pulse that starts and ends strictly between clock edges.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] fill_seq [8];
    fill_seq = '{8'd3, 8'd1, 8'd4, 8'd0, 8'd5, 8'd2, 8'd2, 8'd1};

    rst = 1'b1; val = 1'b1; data = 8'd5; out_rdy = 1'b0;
    #1;
    model_clear();
    check_all("rst_async");
    for (int i = 0; i < 3; i++) step("rst_hold");

    // In-order fill then drain
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      val = 1'b1; data = fill_seq[i];
      step("fill");
    end
    chk("fill_count8", int'(count), 8);
    chk("fill_full",   int'(full), 1);
    val = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_head", int'(out_data), int'(fill_seq[i]));
      step("drain");
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_sum18", int'(sum), 18);

    // Overflow
    async_reset("ovf_rst");
    out_rdy = 1'b0; val = 1'b1; data = 8'd2;
    for (int i = 0; i < 11; i++) step("ovf");
    chk("ovf_count8", int'(count), 8);
    chk("ovf_drop3",  int'(drop_cnt), 3);
    chk("ovf_sum16",  int'(sum), 16);

    // Full with simultaneous pop
    out_rdy = 1'b1; val = 1'b1; data = 8'd4;
    step("fullpop");
    chk("fullpop_count8", int'(count), 8);
    chk("fullpop_drop3",  int'(drop_cnt), 3);
    chk("fullpop_sum20",  int'(sum), 20);
    val = 1'b0;
    for (int i = 0; i < 7; i++) step("fullpop_drain");
    chk("fullpop_tail4", int'(out_data), 4);
    step("fullpop_last");

    // Pass-through with a randomly strobing producer
    async_reset("pt_rst");
    out_rdy = 1'b1; bsum = 0;
    for (int i = 0; i < 50; i++) begin
      val  = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      if (val) bsum = (bsum + int'(data)) % 65536;
      step("pt");
      chk("pt_count_le1", int'(count <= 4'd1), 1);
    end
    chk("pt_drop0", int'(drop_cnt), 0);
    chk("pt_sum",   int'(sum), bsum);

    // Drop-counter saturation
    out_rdy = 1'b0; val = 1'b1;
    for (int i = 0; i < 309; i++) begin
      data = 8'($urandom);
      step("sat");
    end
    chk("sat_drop255", int'(drop_cnt), 255);

    // Reset mid-run
    async_reset("mid_rst0");
    val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 8'($urandom);
      step("mid_fill");
    end
    chk("mid_count5", int'(count), 5);
    async_reset("mid_rst");
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_sum",   int'(sum), 0);
    data = 8'd3;
    step("mid_push");
    chk("mid_head3",  int'(out_data), 3);
    chk("mid_count1", int'(count), 1);

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      val     = 1'($urandom_range(0, 3) != 0);
      out_rdy = 1'($urandom_range(0, 2) == 0);
      data    = 8'($urandom);
      step("rnd");
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
